// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter for the single tiny16 memory port, with fixed
// access latency and locked back-to-back ownership for read-modify-write sequences.
`default_nettype none

module mem_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_we,
  input  logic [NUM_REQ-1:0]        i_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_done,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_mem_en,
  output logic                      o_mem_we,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_wdata,
  input  logic [DATA_W-1:0]         i_mem_rdata
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]      C_CNT_INIT  = CW'(LATENCY - 1);
  localparam logic [OW-1:0]      C_LAST_INIT = OW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] C_ONE       = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1
  } state_t;

  state_t              r_state, w_state;
  logic [OW-1:0]       r_owner, w_owner;
  logic [OW-1:0]       r_last, w_last;
  logic [CW-1:0]       r_cnt, w_cnt;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt;
  logic [NUM_REQ-1:0]  r_done, w_done;
  logic [DATA_W-1:0]   r_rdata, w_rdata;
  logic                r_mem_en, w_mem_en;
  logic                r_mem_we, w_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata;

  logic                w_found;
  logic [OW-1:0]       w_idx;
  logic [OW-1:0]       w_win;
  logic [OW-1:0]       w_sel;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_keep;

  // Round-robin scan starting just after the most recent owner.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = OW'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // The same request mux serves a fresh grant from IDLE and a locked re-grant.
  assign w_sel       = (r_state == S_IDLE) ? w_win : r_owner;
  assign w_sel_we    = i_we[w_sel];
  assign w_sel_addr  = i_addr[w_sel*ADDR_W +: ADDR_W];
  assign w_sel_wdata = i_wdata[w_sel*DATA_W +: DATA_W];
  assign w_keep      = i_lock[r_owner] && i_req[r_owner];

  always_comb begin
    w_state     = r_state;
    w_owner     = r_owner;
    w_last      = r_last;
    w_cnt       = r_cnt;
    w_gnt       = r_gnt;
    w_done      = '0;
    w_rdata     = r_rdata;
    w_mem_en    = r_mem_en;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner     = w_win;
          w_gnt       = C_ONE << w_win;
          w_mem_en    = 1'b1;
          w_mem_we    = w_sel_we;
          w_mem_addr  = w_sel_addr;
          w_mem_wdata = w_sel_wdata;
          w_cnt       = C_CNT_INIT;
          w_state     = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - 1'b1;
        end else begin
          w_done = C_ONE << r_owner;
          w_last = r_owner;
          if (!r_mem_we) begin
            w_rdata = i_mem_rdata;
          end
          if (w_keep) begin
            w_mem_we    = w_sel_we;
            w_mem_addr  = w_sel_addr;
            w_mem_wdata = w_sel_wdata;
            w_cnt       = C_CNT_INIT;
          end else begin
            w_gnt    = '0;
            w_mem_en = 1'b0;
            w_mem_we = 1'b0;
            w_state  = S_IDLE;
          end
        end
      end

      default: begin
        w_state     = S_IDLE;
        w_owner     = '0;
        w_last      = C_LAST_INIT;
        w_cnt       = '0;
        w_gnt       = '0;
        w_rdata     = '0;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_last      <= C_LAST_INIT;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state;
      r_owner     <= w_owner;
      r_last      <= w_last;
      r_cnt       <= w_cnt;
      r_gnt       <= w_gnt;
      r_done      <= w_done;
      r_rdata     <= w_rdata;
      r_mem_en    <= w_mem_en;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_done      = r_done;
  assign o_rdata     = r_rdata;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requester traffic against a transaction-timeline model
// of the arbiter; a monitor pops expected grants/completions from scoreboard queues.
`default_nettype none

module tb_mem_arbiter;

  localparam int N   = 3;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    we = '0;
  logic [N-1:0]    lock = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(req), .i_we(we), .i_lock(lock), .i_addr(addr), .i_wdata(wdata),
    .o_gnt(gnt), .o_done(done), .o_rdata(rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'hBEEF;
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  typedef struct {
    int            owner;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            cyc;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: transactions on a timeline of clock-edge numbers.
  bit            m_busy = 1'b0;
  int            m_own = 0;
  int            m_end = 0;
  int            m_last = N - 1;
  logic [DW-1:0] m_rd = '0;
  exp_t          m_cur;

  task automatic m_start(input int w);
    m_cur.owner = w;
    m_cur.we    = we[w];
    m_cur.a     = addr[w*AW +: AW];
    m_cur.d     = wdata[w*DW +: DW];
    m_cur.cyc   = cyc;
    m_cur.rd    = '0;
    gq.push_back(m_cur);
    m_busy = 1'b1;
    m_own  = w;
    m_end  = cyc + LAT;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (!rst_n) begin
        m_busy = 1'b0;
        m_last = N - 1;
        m_rd   = '0;
        gq.delete();
        dq.delete();
      end else if (m_busy && cyc == m_end) begin
        exp_t e;
        e = m_cur;
        e.cyc = cyc;
        if (!e.we) m_rd = mem_fn(e.a);
        e.rd = m_rd;
        dq.push_back(e);
        m_last = m_own;
        if (lock[m_own] && req[m_own]) m_start(m_own);
        else m_busy = 1'b0;
      end else if (!m_busy && req != '0) begin
        int w;
        w = -1;
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
        end
        m_start(w);
      end
    end
  end

  // Monitor: compares DUT outputs against scoreboard entries.
  initial begin
    logic [N-1:0] prev_gnt;
    bit           have_cur;
    exp_t         cur;
    exp_t         e;
    prev_gnt = '0;
    have_cur = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_gnt = '0;
        have_cur = 1'b0;
        continue;
      end
      chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
      chk("done_onehot0", 64'($onehot0(done)), 64'd1);
      if (done != '0) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", 64'(done), 64'd0);
        end else begin
          e = dq.pop_front();
          chk("done_owner", 64'(done), 64'(1 << e.owner));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("rdata", 64'(rdata), 64'(e.rd));
        end
      end
      if (gnt != '0 && (prev_gnt == '0 || done != '0)) begin
        if (gq.size() == 0) begin
          chk("gnt_unexpected", 64'(gnt), 64'd0);
          have_cur = 1'b0;
        end else begin
          cur = gq.pop_front();
          have_cur = 1'b1;
          chk("gnt_cycle", 64'(cyc), 64'(cur.cyc));
        end
      end
      if (gnt != '0 && have_cur) begin
        chk("gnt_value", 64'(gnt), 64'(1 << cur.owner));
        chk("mem_ctrl", {62'd0, mem_en, mem_we}, {62'd0, 1'b1, cur.we});
        chk("mem_addr", 64'(mem_addr), 64'(cur.a));
        chk("mem_wdata", 64'(mem_wdata), 64'(cur.d));
      end
      if (gnt == '0) begin
        chk("idle_ctrl", {62'd0, mem_en, mem_we}, 64'd0);
      end
      prev_gnt = gnt;
    end
  end

  task automatic drive_rand(input int p_req, input int p_lock);
    for (int i = 0; i < N; i++) begin
      if (!req[i]) req[i] = ($urandom_range(0, 99) < p_req);
      else         req[i] = ($urandom_range(0, 99) < 90);
      lock[i] = ($urandom_range(0, 99) < p_lock);
      we[i]   = $urandom_range(0, 1) == 1;
      addr[i*AW +: AW]  = 16'($urandom);
      wdata[i*DW +: DW] = 16'($urandom);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata});
  endfunction

  initial begin
    bit seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    #2 rst_n = 1'b1;

    // All requesters held high, no lock: pure rotation.
    for (int c = 0; c < 6 * (LAT + 1) + 4; c++) begin
      @(negedge clk);
      req  = '1;
      lock = '0;
      for (int i = 0; i < N; i++) begin
        we[i] = $urandom_range(0, 1) == 1;
        addr[i*AW +: AW]  = 16'($urandom);
        wdata[i*DW +: DW] = 16'($urandom);
      end
    end

    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      drive_rand(30, 20);
    end
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      drive_rand(60, 85);
    end

    // Abort an access owned by requester 1 with an asynchronous reset.
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      req  = 3'b010;
      lock = '0;
      if (gnt == 3'b010) seen = 1'b1;
    end
    chk("wait_gnt1", 64'(seen), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), 64'd0);
    @(negedge clk);
    req  = 3'b110;
    lock = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_reset_first_gnt", 64'(gnt), 64'(3'b010));

    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      drive_rand(40, 50);
    end

    @(negedge clk);
    req  = '0;
    lock = '0;
    repeat (LAT + 6) @(negedge clk);
    chk("drain_gnt_queue", 64'(gq.size()), 64'd0);
    chk("drain_done_queue", 64'(dq.size()), 64'd0);
    chk("drain_idle", {61'd0, gnt, mem_en}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
